// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction is in flight at a time; responses wait for the owner's resp_ready.
module dmem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_wen,
  input  logic [31:0] m0_req_addr,
  input  logic [3:0]  m0_req_wstrb,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [31:0] m0_resp_rdata,
  output logic        m0_resp_err,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_wen,
  input  logic [31:0] m1_req_addr,
  input  logic [3:0]  m1_req_wstrb,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [31:0] m1_resp_rdata,
  output logic        m1_resp_err,

  output logic        dmem_ren,
  output logic [31:0] dmem_raddr,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_wen,
  output logic [31:0] dmem_waddr,
  output logic [31:0] dmem_wstrb,
  output logic [31:0] dmem_wdata,

  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // WAIT runs for cnt+1 cycles, so preload LATENCY-2 to get LATENCY-1 wait cycles.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        owner;
  logic        cap_wen;
  logic [31:0] cap_addr;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        grant;
  logic        accept;
  logic        misaligned;
  logic        resp_take;
  logic        sel_wen;
  logic [31:0] sel_addr;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_wdata;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      grant = ~last_grant;
    end else if (m1_req_valid) begin
      grant = 1'b1;
    end
  end

  assign m0_req_ready = (state == IDLE) && m0_req_valid && !grant;
  assign m1_req_ready = (state == IDLE) && m1_req_valid &&  grant;
  assign accept       = m0_req_ready || m1_req_ready;

  assign sel_wen   = grant ? m1_req_wen   : m0_req_wen;
  assign sel_addr  = grant ? m1_req_addr  : m0_req_addr;
  assign sel_wstrb = grant ? m1_req_wstrb : m0_req_wstrb;
  assign sel_wdata = grant ? m1_req_wdata : m0_req_wdata;

  assign misaligned = |cap_addr[1:0];

  assign dmem_ren   = (state == ISSUE) && !cap_wen && !misaligned;
  assign dmem_wen   = (state == ISSUE) &&  cap_wen && !misaligned;
  assign dmem_raddr = cap_addr;
  assign dmem_waddr = cap_addr;
  assign dmem_wstrb = {28'b0, cap_wstrb};
  assign dmem_wdata = cap_wdata;

  assign m0_resp_valid = (state == RESP) && !owner;
  assign m1_resp_valid = (state == RESP) &&  owner;
  assign m0_resp_rdata = owner ? 32'd0 : rdata_q;
  assign m1_resp_rdata = owner ? rdata_q : 32'd0;
  assign m0_resp_err   = !owner && err_q;
  assign m1_resp_err   =  owner && err_q;
  assign resp_take     = (state == RESP) && (owner ? m1_resp_ready : m0_resp_ready);

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cap_wen    <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wstrb  <= 4'd0;
      cap_wdata  <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            owner      <= grant;
            last_grant <= grant;
            cap_wen    <= sel_wen;
            cap_addr   <= sel_addr;
            cap_wstrb  <= sel_wstrb;
            cap_wdata  <= sel_wdata;
          end
        end
        ISSUE: begin
          // Writes and misaligned accesses return zero data.
          rdata_q <= (cap_wen || misaligned) ? 32'd0 : dmem_rdata;
          err_q   <= misaligned;
          cnt     <= WAIT_INIT;
          state   <= (LATENCY > 1) ? WAIT : RESP;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_take) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: two arbiter instances (LATENCY 1 and 4) share one stimulus set,
// selected by sel, with a byte-strobed memory model and an independent reference memory.
module tb_dmem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic sel = 1'b0;

  logic        m0_req_valid = 1'b0, m0_req_wen = 1'b0, m0_resp_ready = 1'b0;
  logic [31:0] m0_req_addr = 32'd0, m0_req_wdata = 32'd0;
  logic [3:0]  m0_req_wstrb = 4'd0;
  logic        m1_req_valid = 1'b0, m1_req_wen = 1'b0, m1_resp_ready = 1'b0;
  logic [31:0] m1_req_addr = 32'd0, m1_req_wdata = 32'd0;
  logic [3:0]  m1_req_wstrb = 4'd0;

  logic        a_m0_req_ready, a_m1_req_ready, a_m0_resp_valid, a_m1_resp_valid;
  logic        a_m0_resp_err, a_m1_resp_err, a_dmem_ren, a_dmem_wen, a_busy;
  logic [31:0] a_m0_resp_rdata, a_m1_resp_rdata, a_dmem_raddr, a_dmem_rdata;
  logic [31:0] a_dmem_waddr, a_dmem_wstrb, a_dmem_wdata;
  logic        b_m0_req_ready, b_m1_req_ready, b_m0_resp_valid, b_m1_resp_valid;
  logic        b_m0_resp_err, b_m1_resp_err, b_dmem_ren, b_dmem_wen, b_busy;
  logic [31:0] b_m0_resp_rdata, b_m1_resp_rdata, b_dmem_raddr, b_dmem_rdata;
  logic [31:0] b_dmem_waddr, b_dmem_wstrb, b_dmem_wdata;

  logic        m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid;
  logic        m0_resp_err, m1_resp_err, dmem_ren, dmem_wen, busy;
  logic [31:0] m0_resp_rdata, m1_resp_rdata, dmem_raddr, dmem_waddr, dmem_wstrb, dmem_wdata;

  assign m0_req_ready  = sel ? b_m0_req_ready  : a_m0_req_ready;
  assign m1_req_ready  = sel ? b_m1_req_ready  : a_m1_req_ready;
  assign m0_resp_valid = sel ? b_m0_resp_valid : a_m0_resp_valid;
  assign m1_resp_valid = sel ? b_m1_resp_valid : a_m1_resp_valid;
  assign m0_resp_err   = sel ? b_m0_resp_err   : a_m0_resp_err;
  assign m1_resp_err   = sel ? b_m1_resp_err   : a_m1_resp_err;
  assign m0_resp_rdata = sel ? b_m0_resp_rdata : a_m0_resp_rdata;
  assign m1_resp_rdata = sel ? b_m1_resp_rdata : a_m1_resp_rdata;
  assign dmem_ren      = sel ? b_dmem_ren      : a_dmem_ren;
  assign dmem_wen      = sel ? b_dmem_wen      : a_dmem_wen;
  assign dmem_raddr    = sel ? b_dmem_raddr    : a_dmem_raddr;
  assign dmem_waddr    = sel ? b_dmem_waddr    : a_dmem_waddr;
  assign dmem_wstrb    = sel ? b_dmem_wstrb    : a_dmem_wstrb;
  assign dmem_wdata    = sel ? b_dmem_wdata    : a_dmem_wdata;
  assign busy          = sel ? b_busy          : a_busy;

  dmem_arbiter #(.LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid && !sel), .m0_req_ready(a_m0_req_ready),
    .m0_req_wen(m0_req_wen), .m0_req_addr(m0_req_addr), .m0_req_wstrb(m0_req_wstrb),
    .m0_req_wdata(m0_req_wdata), .m0_resp_valid(a_m0_resp_valid),
    .m0_resp_ready(m0_resp_ready && !sel), .m0_resp_rdata(a_m0_resp_rdata), .m0_resp_err(a_m0_resp_err),
    .m1_req_valid(m1_req_valid && !sel), .m1_req_ready(a_m1_req_ready),
    .m1_req_wen(m1_req_wen), .m1_req_addr(m1_req_addr), .m1_req_wstrb(m1_req_wstrb),
    .m1_req_wdata(m1_req_wdata), .m1_resp_valid(a_m1_resp_valid),
    .m1_resp_ready(m1_resp_ready && !sel), .m1_resp_rdata(a_m1_resp_rdata), .m1_resp_err(a_m1_resp_err),
    .dmem_ren(a_dmem_ren), .dmem_raddr(a_dmem_raddr), .dmem_rdata(a_dmem_rdata),
    .dmem_wen(a_dmem_wen), .dmem_waddr(a_dmem_waddr), .dmem_wstrb(a_dmem_wstrb),
    .dmem_wdata(a_dmem_wdata), .busy(a_busy)
  );

  dmem_arbiter #(.LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid && sel), .m0_req_ready(b_m0_req_ready),
    .m0_req_wen(m0_req_wen), .m0_req_addr(m0_req_addr), .m0_req_wstrb(m0_req_wstrb),
    .m0_req_wdata(m0_req_wdata), .m0_resp_valid(b_m0_resp_valid),
    .m0_resp_ready(m0_resp_ready && sel), .m0_resp_rdata(b_m0_resp_rdata), .m0_resp_err(b_m0_resp_err),
    .m1_req_valid(m1_req_valid && sel), .m1_req_ready(b_m1_req_ready),
    .m1_req_wen(m1_req_wen), .m1_req_addr(m1_req_addr), .m1_req_wstrb(m1_req_wstrb),
    .m1_req_wdata(m1_req_wdata), .m1_resp_valid(b_m1_resp_valid),
    .m1_resp_ready(m1_resp_ready && sel), .m1_resp_rdata(b_m1_resp_rdata), .m1_resp_err(b_m1_resp_err),
    .dmem_ren(b_dmem_ren), .dmem_raddr(b_dmem_raddr), .dmem_rdata(b_dmem_rdata),
    .dmem_wen(b_dmem_wen), .dmem_waddr(b_dmem_waddr), .dmem_wstrb(b_dmem_wstrb),
    .dmem_wdata(b_dmem_wdata), .busy(b_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_q[$];
  int          check_count = 0;
  int          error_count = 0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  logic [31:0] last_wstrb = 32'd0;
  logic [31:0] last_raddr = 32'd0;

  logic [31:0] mem [256];
  logic [255:0] written = '0;
  logic [31:0] ref_mem [256];
  logic [255:0] ref_written = '0;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    if (i == 8'd1) return 32'hDEADBEEF;
    return {i, 8'hA5, ~i, 8'h3C};
  endfunction

  always_comb begin
    a_dmem_rdata = written[a_dmem_raddr[9:2]] ? mem[a_dmem_raddr[9:2]] : init_word(a_dmem_raddr[9:2]);
    b_dmem_rdata = written[b_dmem_raddr[9:2]] ? mem[b_dmem_raddr[9:2]] : init_word(b_dmem_raddr[9:2]);
  end

  // Memory model applies byte strobes on the clock edge that ends the write cycle.
  always @(posedge clock) begin
    if (dmem_wen) begin
      logic [31:0] w;
      w = written[dmem_waddr[9:2]] ? mem[dmem_waddr[9:2]] : init_word(dmem_waddr[9:2]);
      for (int b = 0; b < 4; b++) if (dmem_wstrb[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
      mem[dmem_waddr[9:2]] <= w;
      written[dmem_waddr[9:2]] <= 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic owner, input logic wen, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    exp_t e;
    logic [31:0] w;
    w = ref_written[addr[9:2]] ? ref_mem[addr[9:2]] : init_word(addr[9:2]);
    e.owner = owner;
    e.err   = (addr[1:0] != 2'b00);
    e.rdata = (wen || e.err) ? 32'd0 : w;
    if (wen && !e.err) begin
      for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[addr[9:2]] = w;
      ref_written[addr[9:2]] = 1'b1;
    end
    exp_q.push_back(e);
    grant_q.push_back(int'(owner));
  endtask

  task automatic pop_cmp(input logic owner, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_output("unexpected_resp", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_output("resp_owner", {31'd0, owner}, {31'd0, e.owner});
    check_output("resp_rdata", rdata, e.rdata);
    check_output("resp_err", {31'd0, err}, {31'd0, e.err});
  endtask

  // Inputs change 1 time unit after posedge, so negedge sees the values the next edge will use.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (dmem_ren) begin ren_cnt++; last_raddr = dmem_raddr; end
      if (dmem_wen) begin wen_cnt++; last_wstrb = dmem_wstrb; end
      if (busy) check_output("ready_while_busy", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
      if (m0_req_valid && m0_req_ready) push_exp(1'b0, m0_req_wen, m0_req_addr, m0_req_wstrb, m0_req_wdata);
      if (m1_req_valid && m1_req_ready) push_exp(1'b1, m1_req_wen, m1_req_addr, m1_req_wstrb, m1_req_wdata);
      if (m0_resp_valid && m1_resp_valid) check_output("dual_resp", 32'd1, 32'd0);
      if (m0_resp_valid && m0_resp_ready) pop_cmp(1'b0, m0_resp_rdata, m0_resp_err);
      if (m1_resp_valid && m1_resp_ready) pop_cmp(1'b1, m1_resp_rdata, m1_resp_err);
    end
  end

  function automatic logic resp_valid_of(input int m);
    return (m == 0) ? m0_resp_valid : m1_resp_valid;
  endfunction
  function automatic logic [31:0] resp_rdata_of(input int m);
    return (m == 0) ? m0_resp_rdata : m1_resp_rdata;
  endfunction
  function automatic logic resp_err_of(input int m);
    return (m == 0) ? m0_resp_err : m1_resp_err;
  endfunction

  // One directed transaction: accept, measure latency, stall, then release resp_ready.
  task automatic apply_stimulus(input int m, input logic wen, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata,
                                input int lat, input int stall);
    int n, ren0, wen0;
    bit got;
    logic [31:0] held_rdata;
    logic held_err, err_exp;
    err_exp = (addr[1:0] != 2'b00);
    if (m == 0) begin
      m0_req_wen = wen; m0_req_addr = addr; m0_req_wstrb = wstrb; m0_req_wdata = wdata; m0_req_valid = 1'b1;
    end else begin
      m1_req_wen = wen; m1_req_addr = addr; m1_req_wstrb = wstrb; m1_req_wdata = wdata; m1_req_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      got = (m == 0) ? m0_req_ready : m1_req_ready;
    end
    ren0 = ren_cnt;
    wen0 = wen_cnt;
    @(posedge clock); #1;
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    if (!got) begin
      check_output("accept_timeout", 32'd0, 32'd1);
      return;
    end
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      n++;
      got = resp_valid_of(m);
    end
    if (!got) begin
      check_output("resp_timeout", 32'd0, 32'd1);
      return;
    end
    check_output("resp_latency", n, lat + 1);
    held_rdata = resp_rdata_of(m);
    held_err   = resp_err_of(m);
    for (int i = 1; i < stall; i++) begin
      @(negedge clock);
      check_output("hold_valid", {31'd0, resp_valid_of(m)}, 32'd1);
      check_output("hold_rdata", resp_rdata_of(m), held_rdata);
      check_output("hold_err", {31'd0, resp_err_of(m)}, {31'd0, held_err});
    end
    @(posedge clock); #1;
    if (m == 0) m0_resp_ready = 1'b1; else m1_resp_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    m0_resp_ready = 1'b0;
    m1_resp_ready = 1'b0;
    check_output("idle_after_resp", {31'd0, busy}, 32'd0);
    check_output("valid_after_resp", {31'd0, resp_valid_of(m)}, 32'd0);
    check_output("ren_pulses", ren_cnt - ren0, (!wen && !err_exp) ? 32'd1 : 32'd0);
    check_output("wen_pulses", wen_cnt - wen0, (wen && !err_exp) ? 32'd1 : 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_resp_valid", {30'd0, m1_resp_valid, m0_resp_valid}, 32'd0);
    check_output("rst_dmem_en", {30'd0, dmem_wen, dmem_ren}, 32'd0);
    check_output("rst_rdata", m0_resp_rdata | m1_resp_rdata, 32'd0);
    check_output("rst_err", {30'd0, m1_resp_err, m0_resp_err}, 32'd0);
    check_output("rst_waddr", dmem_waddr | dmem_wdata, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy && exp_q.size() == 0) break;
    end
    check_output("drain_busy", {31'd0, busy}, 32'd0);
    check_output("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0, wen0;
    bit any_resp;
    #2;
    apply_reset();

    // LATENCY=1 instance
    sel = 1'b0;
    apply_stimulus(0, 1'b0, 32'h80000004, 4'h0, 32'd0, LAT_A, 1);
    check_output("read_raddr", last_raddr, 32'h80000004);
    check_output("raddr_hold", dmem_raddr, 32'h80000004);
    apply_stimulus(1, 1'b1, 32'h00000100, 4'b0011, 32'h12345678, LAT_A, 1);
    check_output("write_wstrb", last_wstrb, 32'h00000003);
    apply_stimulus(1, 1'b0, 32'h00000100, 4'h0, 32'd0, LAT_A, 2);
    apply_stimulus(0, 1'b0, 32'h00000102, 4'h0, 32'd0, LAT_A, 1);
    apply_stimulus(0, 1'b1, 32'h00000104, 4'b0000, 32'hFFFFFFFF, LAT_A, 1);
    check_output("zero_wstrb", last_wstrb, 32'd0);
    apply_stimulus(0, 1'b0, 32'h00000104, 4'h0, 32'd0, LAT_A, 1);

    // Tie with responses always taken: grants must alternate starting with m0.
    apply_reset();
    g0 = grant_q.size();
    m0_req_wen = 1'b0; m0_req_addr = 32'h00000008;
    m1_req_wen = 1'b0; m1_req_addr = 32'h0000000C;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    repeat (24) @(posedge clock);
    #1;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    wait_drain();
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    check_output("tie_grant_count", (grant_q.size() - g0 >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = g0; i < grant_q.size(); i++) check_output("tie_order", grant_q[i], (i - g0) % 2);

    // LATENCY=4 instance
    @(posedge clock); #1;
    sel = 1'b1;
    apply_stimulus(0, 1'b0, 32'h80000004, 4'h0, 32'd0, LAT_B, 3);
    apply_stimulus(1, 1'b1, 32'h00000103, 4'hF, 32'hAAAA5555, LAT_B, 2);
    apply_stimulus(1, 1'b1, 32'h00000040, 4'b1100, 32'hBEEF0000, LAT_B, 1);
    apply_stimulus(0, 1'b0, 32'h00000040, 4'h0, 32'd0, LAT_B, 1);

    // Reset during WAIT of a write abandons it.
    m0_req_wen = 1'b1; m0_req_addr = 32'h00000020; m0_req_wstrb = 4'hF; m0_req_wdata = 32'hCAFEF00D;
    m0_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (m0_req_ready) break;
    end
    wen0 = wen_cnt;
    @(posedge clock); #1;
    m0_req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_output("mid_wait_busy", {31'd0, busy}, 32'd1);
    check_output("pre_reset_wen", wen_cnt - wen0, 32'd1);
    apply_reset();
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    any_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      any_resp = any_resp | m0_resp_valid | m1_resp_valid;
    end
    check_output("abandoned_resp", {31'd0, any_resp}, 32'd0);
    check_output("abandoned_wen", wen_cnt - wen0, 32'd1);
    @(posedge clock); #1;
    m0_req_wen = 1'b0; m0_req_addr = 32'h00000020;
    m1_req_wen = 1'b0; m1_req_addr = 32'h00000024;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    @(negedge clock);
    check_output("post_reset_tie", {30'd0, m1_req_ready, m0_req_ready}, 32'd1);
    @(posedge clock); #1;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    wait_drain();
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
